// File: rtl/endec_axis_sequencer.sv
// Job sequencer between the 64-bit AXI-Stream host link and the encoder/decoder core:
// config beat, data packet, core start/wait, then the result packet back to the host.
module endec_axis_sequencer #(
   parameter int DATA_W      = 64,
   parameter int GEN_POLY_W  = 27,
   parameter int STATE_W     = 8,
   parameter int ENC_W       = 128,
   parameter int DEC_W       = 384,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [DATA_W-1:0]     m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  o_code_rate,
   output logic [GEN_POLY_W-1:0] o_gen_poly_flat,
   output logic [STATE_W-1:0]    o_prv_encoder_state,
   output logic [ENC_W-1:0]      o_encoder_frame,
   output logic [DEC_W-1:0]      o_decoder_frame,
   output logic                  o_core_en,
   output logic                  o_core_start,
   input  logic [DEC_W-1:0]      i_encoder_data,
   input  logic                  i_encoder_done,
   input  logic [ENC_W-1:0]      i_decoder_data,
   input  logic                  i_decoder_done,
   output logic                  o_busy,
   output logic                  o_err_framing,
   output logic                  o_err_timeout
);
   localparam int FRAME_W = ENC_W + DEC_W;
   localparam int BEATS   = FRAME_W / DATA_W;
   localparam int CNT_W   = $clog2(BEATS);
   localparam int TO_W    = $clog2(TIMEOUT_CYC);

   typedef enum logic [2:0] {S_CFG, S_DATA, S_START, S_WAIT, S_SEND} state_t;

   state_t                   state_q, state_d;
   logic                     run_q;
   logic [CNT_W-1:0]         in_cnt_q, out_cnt_q;
   logic [TO_W-1:0]          to_cnt_q;
   logic                     enc_flag_q, dec_flag_q;
   logic [FRAME_W-DATA_W-1:0] in_sreg_q;
   logic [FRAME_W-1:0]       out_sreg_q;
   logic [FRAME_W-1:0]       in_frame;
   logic                     in_fire, out_fire, last_beat, both_done, timeout, framing_err;

   // run_q keeps tready low while reset is asserted and for the first cycle after it
   assign s_axis_tready = run_q && (state_q == S_CFG || state_q == S_DATA);
   assign m_axis_tvalid = (state_q == S_SEND);
   assign m_axis_tdata  = out_sreg_q[FRAME_W-1 -: DATA_W];
   assign m_axis_tlast  = m_axis_tvalid && (out_cnt_q == CNT_W'(BEATS-1));
   assign o_core_start  = (state_q == S_START);
   assign o_core_en     = (state_q == S_START) || (state_q == S_WAIT);
   assign o_busy        = (state_q != S_CFG);

   assign in_fire   = s_axis_tvalid && s_axis_tready;
   assign out_fire  = m_axis_tvalid && m_axis_tready;
   assign last_beat = (in_cnt_q == CNT_W'(BEATS-1));
   assign in_frame  = {in_sreg_q, s_axis_tdata};
   assign both_done = (enc_flag_q || i_encoder_done) && (dec_flag_q || i_decoder_done);
   assign timeout   = (to_cnt_q == TO_W'(TIMEOUT_CYC-1));

   always_comb begin
      state_d     = state_q;
      framing_err = 1'b0;
      case (state_q)
         S_CFG:
            if (in_fire) begin
               if (s_axis_tlast) state_d = S_DATA;
               else              framing_err = 1'b1;
            end
         S_DATA:
            if (in_fire) begin
               if (s_axis_tlast != last_beat) framing_err = 1'b1;
               else if (last_beat)            state_d = S_START;
            end
         S_START: state_d = S_WAIT;
         S_WAIT:
            if (both_done)    state_d = S_SEND;
            else if (timeout) state_d = S_CFG;
         S_SEND:
            if (out_fire && out_cnt_q == CNT_W'(BEATS-1)) state_d = S_CFG;
         default: state_d = S_CFG;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q             <= S_CFG;
         run_q               <= 1'b0;
         in_cnt_q            <= '0;
         out_cnt_q           <= '0;
         to_cnt_q            <= '0;
         enc_flag_q          <= 1'b0;
         dec_flag_q          <= 1'b0;
         in_sreg_q           <= '0;
         out_sreg_q          <= '0;
         o_code_rate         <= 1'b0;
         o_gen_poly_flat     <= '0;
         o_prv_encoder_state <= '0;
         o_encoder_frame     <= '0;
         o_decoder_frame     <= '0;
         o_err_framing       <= 1'b0;
         o_err_timeout       <= 1'b0;
      end else begin
         state_q       <= state_d;
         run_q         <= 1'b1;
         o_err_framing <= framing_err;
         o_err_timeout <= (state_q == S_WAIT) && timeout && !both_done;
         case (state_q)
            S_CFG:
               if (in_fire && s_axis_tlast) begin
                  o_gen_poly_flat     <= s_axis_tdata[GEN_POLY_W-1:0];
                  o_code_rate         <= s_axis_tdata[GEN_POLY_W];
                  o_prv_encoder_state <= s_axis_tdata[GEN_POLY_W+STATE_W:GEN_POLY_W+1];
               end
            S_DATA:
               if (in_fire) begin
                  in_sreg_q <= in_frame[FRAME_W-DATA_W-1:0];
                  in_cnt_q  <= (s_axis_tlast || last_beat) ? '0 : in_cnt_q + 1'b1;
                  if (s_axis_tlast && last_beat) begin
                     o_decoder_frame <= in_frame[FRAME_W-1 -: DEC_W];
                     o_encoder_frame <= in_frame[ENC_W-1:0];
                  end
               end
            S_START: begin
               to_cnt_q   <= '0;
               enc_flag_q <= 1'b0;
               dec_flag_q <= 1'b0;
            end
            S_WAIT: begin
               // each result is parked in the output register on its own done, so
               // a core that drops its data after the pulse still returns it intact
               to_cnt_q <= to_cnt_q + 1'b1;
               if (i_decoder_done && !dec_flag_q) begin
                  out_sreg_q[FRAME_W-1 -: ENC_W] <= i_decoder_data;
                  dec_flag_q                     <= 1'b1;
               end
               if (i_encoder_done && !enc_flag_q) begin
                  out_sreg_q[DEC_W-1:0] <= i_encoder_data;
                  enc_flag_q            <= 1'b1;
               end
               if (timeout && !both_done) begin
                  enc_flag_q <= 1'b0;
                  dec_flag_q <= 1'b0;
               end
            end
            S_SEND:
               if (out_fire) begin
                  out_sreg_q <= out_sreg_q << DATA_W;
                  out_cnt_q  <= out_cnt_q + 1'b1;
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_endec_axis_sequencer.sv
// Self-checking bench for endec_axis_sequencer: random jobs against a packet-level model
// of the expected frames, result beats, pulses and latencies.
module tb_endec_axis_sequencer;
   localparam int DATA_W      = 64;
   localparam int GEN_POLY_W  = 27;
   localparam int STATE_W     = 8;
   localparam int ENC_W       = 128;
   localparam int DEC_W       = 384;
   localparam int TIMEOUT_CYC = 4096;

   logic                  sys_clk = 1'b0;
   logic                  rst_n;
   logic [DATA_W-1:0]     s_axis_tdata;
   logic                  s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [DATA_W-1:0]     m_axis_tdata;
   logic                  m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic                  o_code_rate;
   logic [GEN_POLY_W-1:0] o_gen_poly_flat;
   logic [STATE_W-1:0]    o_prv_encoder_state;
   logic [ENC_W-1:0]      o_encoder_frame;
   logic [DEC_W-1:0]      o_decoder_frame;
   logic                  o_core_en, o_core_start;
   logic [DEC_W-1:0]      i_encoder_data;
   logic                  i_encoder_done;
   logic [ENC_W-1:0]      i_decoder_data;
   logic                  i_decoder_done;
   logic                  o_busy, o_err_framing, o_err_timeout;

   int checks = 0, errors = 0;
   int n_start = 0, n_ferr = 0, n_terr = 0;
   logic [63:0] last_cfg = '0;

   endec_axis_sequencer dut (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready),
      .o_code_rate(o_code_rate), .o_gen_poly_flat(o_gen_poly_flat),
      .o_prv_encoder_state(o_prv_encoder_state),
      .o_encoder_frame(o_encoder_frame), .o_decoder_frame(o_decoder_frame),
      .o_core_en(o_core_en), .o_core_start(o_core_start),
      .i_encoder_data(i_encoder_data), .i_encoder_done(i_encoder_done),
      .i_decoder_data(i_decoder_data), .i_decoder_done(i_decoder_done),
      .o_busy(o_busy), .o_err_framing(o_err_framing), .o_err_timeout(o_err_timeout)
   );

   always #5 sys_clk = ~sys_clk;

   // pulse counters, sampled mid-cycle
   always @(negedge sys_clk) begin
      if (o_core_start)  n_start++;
      if (o_err_framing) n_ferr++;
      if (o_err_timeout) n_terr++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   function automatic logic [511:0] rnd_wide();
      logic [511:0] r = '0;
      for (int i = 0; i < 16; i++) r = {r[479:0], $urandom()};
      return r;
   endfunction

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic put_beat(input logic [63:0] d, input logic last, input int gap, output bit ok);
      repeat (gap) step();
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge sys_clk);
         if (s_axis_tready) ok = 1;
         step();
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL in_accept: beat %h not accepted within 50 cycles, required accept", d);
      end
   endtask

   task automatic recv(input logic [511:0] res, input int mode, input int n_out);
      int idx = 0, cyc = 0;
      bit hold = 0;
      logic [63:0]  held = '0, exp_d;
      logic [511:0] sh;
      while (idx < n_out && cyc < 400) begin
         step();
         case (mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = (cyc % 2 == 0);
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
         @(negedge sys_clk);
         cyc++;
         if (hold) begin
            checks++;
            if (!m_axis_tvalid || m_axis_tdata !== held) begin
               errors++;
               $display("FAIL out_stall_hold: tvalid %0b tdata %h, required 1 %h", m_axis_tvalid, m_axis_tdata, held);
            end
            hold = 0;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            sh = res >> (DATA_W * (7 - idx));
            exp_d = sh[63:0];
            checks++;
            if (m_axis_tdata !== exp_d) begin
               errors++;
               $display("FAIL out_beat%0d: got %h, required %h", idx, m_axis_tdata, exp_d);
            end
            checks++;
            if (m_axis_tlast !== (idx == 7)) begin
               errors++;
               $display("FAIL out_tlast%0d: got %0b, required %0b", idx, m_axis_tlast, idx == 7);
            end
            idx++;
         end else if (m_axis_tvalid) begin
            hold = 1;
            held = m_axis_tdata;
         end
      end
      checks++;
      if (idx < n_out) begin
         errors++;
         $display("FAIL out_count: got %0d beats, required %0d", idx, n_out);
      end
      step();
      m_axis_tready = 1'b0;
      if (n_out == 8) begin
         @(negedge sys_clk);
         checks++;
         if (m_axis_tvalid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL out_end: tvalid %0b busy %0b, required 0 0", m_axis_tvalid, o_busy);
         end
         step();
      end
   endtask

   // One job: cfg (optional), 8 data beats, core done after d_dec/d_enc S_WAIT cycles, result read-back
   task automatic run_job(input logic [63:0] cfg, input bit do_cfg, input int gap_max,
                          input int d_dec, input int d_enc, input int out_mode, input int n_out);
      logic [63:0]      beats[8];
      logic [511:0]     w, res;
      logic [DEC_W-1:0] dec_exp, enc_res;
      logic [ENC_W-1:0] enc_exp, dec_res;
      int s0, dmax;
      bit ok;
      s0 = n_start;
      for (int i = 0; i < 8; i++) begin w = rnd_wide(); beats[i] = w[63:0]; end
      w = rnd_wide(); enc_res = w[DEC_W-1:0];
      w = rnd_wide(); dec_res = w[ENC_W-1:0];
      res = {dec_res, enc_res};
      dec_exp = '0;
      for (int i = 0; i < 6; i++) dec_exp = (dec_exp << 64) | DEC_W'(beats[i]);
      enc_exp = {beats[6], beats[7]};
      if (do_cfg) begin
         put_beat(cfg, 1'b1, $urandom_range(0, gap_max), ok);
         last_cfg = cfg;
      end
      @(negedge sys_clk);
      checks++;
      if ({o_prv_encoder_state, o_code_rate, o_gen_poly_flat} !== cfg[35:0]) begin
         errors++;
         $display("FAIL cfg_fields: got %h, required %h", {o_prv_encoder_state, o_code_rate, o_gen_poly_flat}, cfg[35:0]);
      end
      step();
      for (int i = 0; i < 8; i++) put_beat(beats[i], i == 7, $urandom_range(0, gap_max), ok);
      @(negedge sys_clk);
      checks++;
      if (o_core_start !== 1'b1) begin
         errors++;
         $display("FAIL start_latency: core_start %0b, required 1", o_core_start);
      end
      checks++;
      if (o_decoder_frame !== dec_exp || o_encoder_frame !== enc_exp) begin
         errors++;
         $display("FAIL frames: dec %h enc %h, required %h %h", o_decoder_frame, o_encoder_frame, dec_exp, enc_exp);
      end
      dmax = (d_dec > d_enc) ? d_dec : d_enc;
      for (int k = 1; k <= dmax; k++) begin
         step();
         i_decoder_done = (k == d_dec);
         i_encoder_done = (k == d_enc);
         w = rnd_wide();
         i_decoder_data = (k == d_dec) ? dec_res : w[ENC_W-1:0];
         i_encoder_data = (k == d_enc) ? enc_res : w[511:512-DEC_W];
         if (k == dmax) begin
            @(negedge sys_clk);
            checks++;
            if (m_axis_tvalid !== 1'b0 || o_core_en !== 1'b1) begin
               errors++;
               $display("FAIL wait_state: tvalid %0b core_en %0b, required 0 1", m_axis_tvalid, o_core_en);
            end
         end
      end
      step();
      i_decoder_done = 1'b0;
      i_encoder_done = 1'b0;
      w = rnd_wide();
      i_decoder_data = w[ENC_W-1:0];
      i_encoder_data = w[511:512-DEC_W];
      @(negedge sys_clk);
      checks++;
      if (m_axis_tvalid !== 1'b1 || o_core_en !== 1'b0) begin
         errors++;
         $display("FAIL send_latency: tvalid %0b core_en %0b, required 1 0", m_axis_tvalid, o_core_en);
      end
      checks++;
      if (n_start - s0 !== 1) begin
         errors++;
         $display("FAIL start_count: got %0d pulses, required 1", n_start - s0);
      end
      recv(res, out_mode, n_out);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, o_code_rate, o_core_en, o_core_start,
           o_busy, o_err_framing, o_err_timeout} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, required 0", {s_axis_tready, m_axis_tvalid, m_axis_tlast,
                  o_code_rate, o_core_en, o_core_start, o_busy, o_err_framing, o_err_timeout});
      end
      checks++;
      if (m_axis_tdata !== '0 || o_gen_poly_flat !== '0 || o_prv_encoder_state !== '0) begin
         errors++;
         $display("FAIL reset_data: tdata %h poly %h state %h, required 0", m_axis_tdata, o_gen_poly_flat, o_prv_encoder_state);
      end
      checks++;
      if (o_encoder_frame !== '0 || o_decoder_frame !== '0) begin
         errors++;
         $display("FAIL reset_frames: enc %h dec %h, required 0", o_encoder_frame, o_decoder_frame);
      end
      step();
      rst_n = 1'b1;
      step();
      @(negedge sys_clk);
      checks++;
      if (s_axis_tready !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: tready %0b busy %0b, required 1 0", s_axis_tready, o_busy);
      end
      step();
   endtask

   task automatic test_nominal();
      logic [63:0] cfg;
      cfg = {$urandom(), $urandom()};
      cfg[35:0] = {8'h52, 1'b1, 9'b100100111, 9'b110011011, 9'b111101101};
      run_job(cfg, 1'b1, 0, 40, 40, 0, 8);
   endtask

   task automatic test_backpressure();
      run_job({$urandom(), $urandom()}, 1'b1, 3, 7, 7, 1, 8);
      run_job({$urandom(), $urandom()}, 1'b1, 4, 3, 9, 2, 8);
   endtask

   task automatic test_split_done();
      run_job({$urandom(), $urandom()}, 1'b1, 0, 10, 15, 0, 8);
      run_job({$urandom(), $urandom()}, 1'b1, 1, 20, 12, 1, 8);
   endtask

   task automatic test_framing();
      logic [63:0] good, prev;
      int f0, s0;
      bit ok;
      f0 = n_ferr;
      s0 = n_start;
      prev = last_cfg;
      put_beat({$urandom(), $urandom()}, 1'b0, 0, ok);
      step(); step();
      @(negedge sys_clk);
      checks++;
      if ({o_prv_encoder_state, o_code_rate, o_gen_poly_flat} !== prev[35:0] || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL cfg_no_last: cfg %h busy %0b, required %h 0",
                  {o_prv_encoder_state, o_code_rate, o_gen_poly_flat}, o_busy, prev[35:0]);
      end
      step();
      good = {$urandom(), $urandom()};
      put_beat(good, 1'b1, 0, ok);
      last_cfg = good;
      for (int i = 0; i < 4; i++) put_beat({$urandom(), $urandom()}, i == 3, 0, ok);
      for (int i = 0; i < 8; i++) put_beat({$urandom(), $urandom()}, 1'b0, 0, ok);
      step(); step();
      checks++;
      if (n_ferr - f0 !== 3) begin
         errors++;
         $display("FAIL framing_count: got %0d pulses, required 3", n_ferr - f0);
      end
      checks++;
      if (n_start !== s0 || o_busy !== 1'b1 || s_axis_tready !== 1'b1) begin
         errors++;
         $display("FAIL framing_state: starts %0d busy %0b tready %0b, required 0 1 1", n_start - s0, o_busy, s_axis_tready);
      end
      run_job(good, 1'b0, 1, 5, 6, 0, 8);
   endtask

   task automatic test_timeout();
      int k, t0;
      bit ok, seen;
      t0 = n_terr;
      put_beat({$urandom(), $urandom()}, 1'b1, 0, ok);
      for (int i = 0; i < 8; i++) put_beat({$urandom(), $urandom()}, i == 7, 0, ok);
      k = 0;
      seen = 0;
      while (!seen && k < TIMEOUT_CYC + 20) begin
         @(negedge sys_clk);
         if (o_err_timeout) seen = 1;
         else begin step(); k++; end
      end
      checks++;
      if (!seen || k < TIMEOUT_CYC || k > TIMEOUT_CYC + 1) begin
         errors++;
         $display("FAIL timeout_latency: seen %0b after %0d cycles, required 1 in %0d..%0d", seen, k, TIMEOUT_CYC, TIMEOUT_CYC + 1);
      end
      step();
      @(negedge sys_clk);
      checks++;
      if (o_busy !== 1'b0 || s_axis_tready !== 1'b1 || o_core_en !== 1'b0 || o_err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: busy %0b tready %0b core_en %0b err %0b, required 0 1 0 0",
                  o_busy, s_axis_tready, o_core_en, o_err_timeout);
      end
      step();
      checks++;
      if (n_terr - t0 !== 1) begin
         errors++;
         $display("FAIL timeout_count: got %0d pulses, required 1", n_terr - t0);
      end
      run_job({$urandom(), $urandom()}, 1'b1, 0, 2, 2, 0, 8);
   endtask

   task automatic test_back_to_back();
      run_job({$urandom(), $urandom()}, 1'b1, 0, 1, 1, 0, 8);
      for (int j = 0; j < 3; j++)
         run_job({$urandom(), $urandom()}, 1'b1, 0, $urandom_range(1, 12), $urandom_range(1, 12), 2, 8);
   endtask

   task automatic test_reset_mid();
      run_job({$urandom(), $urandom()}, 1'b1, 0, 4, 4, 0, 4);
      rst_n = 1'b0;
      @(negedge sys_clk);
      checks++;
      if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, o_core_en, o_core_start, o_busy} !== '0 ||
          m_axis_tdata !== '0 || o_decoder_frame !== '0 || o_encoder_frame !== '0) begin
         errors++;
         $display("FAIL midreset_zero: ctrl %b tdata %h, required 0", {s_axis_tready, m_axis_tvalid,
                  m_axis_tlast, o_core_en, o_core_start, o_busy}, m_axis_tdata);
      end
      step(); step();
      rst_n = 1'b1;
      m_axis_tready = 1'b1;
      step(); step();
      @(negedge sys_clk);
      checks++;
      if (m_axis_tvalid !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_resume: tvalid %0b busy %0b, required 0 0", m_axis_tvalid, o_busy);
      end
      step();
      m_axis_tready = 1'b0;
      run_job({$urandom(), $urandom()}, 1'b1, 0, 3, 5, 0, 8);
   endtask

   initial begin
      s_axis_tdata   = '0;
      s_axis_tvalid  = 1'b0;
      s_axis_tlast   = 1'b0;
      m_axis_tready  = 1'b0;
      i_encoder_data = '0;
      i_encoder_done = 1'b0;
      i_decoder_data = '0;
      i_decoder_done = 1'b0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_split_done();
      test_framing();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
